step_dir_decoder: RTL and testbench

- Receiving end of the step/direction interface driven by Motor_Control: consumes one step line and one direction line.
- Reconstructs signed axis position, per-move step count, and move-complete events.
- Checks the direction-to-step setup time.
- One instance per axis. Used as a position monitor and closed-loop check beside the x/y motor drivers, and as the bench-side checker for motor sequencing blocks.

---
 rtl/step_dir_decoder.sv | 159 +++++++++++++++
 tb/tb_step_dir_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_decoder.sv
// Step/direction receiver: rebuilds signed axis position, per-move step count and
// move-complete events from a synchronised step/direction pair, with setup/limit checks.
module step_dir_decoder #(
  parameter int POS_W       = 16,
  parameter int CNT_W       = 15,
  parameter int SYNC_STAGES = 2,
  parameter int DIR_SETUP   = 4,
  parameter int IDLE_CYCLES = 50000,
  parameter int POS_MIN     = -16000,
  parameter int POS_MAX     = 16000
) (
  input  logic                    i_Clk,
  input  logic                    i_rst_n,
  input  logic                    i_step,
  input  logic                    i_direction,
  input  logic                    i_preset,
  input  logic signed [POS_W-1:0] i_preset_val,
  input  logic                    i_clr_err,
  output logic signed [POS_W-1:0] o_position,
  output logic [CNT_W-1:0]        o_move_steps,
  output logic                    o_moving,
  output logic                    o_move_done,
  output logic                    o_dir_err,
  output logic                    o_limit_err
);

  localparam int DCW = $clog2(DIR_SETUP + 2);
  localparam int TW  = $clog2(IDLE_CYCLES + 1);

  typedef enum logic {S_IDLE, S_MOVING} state_t;

  function automatic logic out_of_range(input logic signed [POS_W-1:0] p);
    return (int'(p) < POS_MIN) || (int'(p) > POS_MAX);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] step_sync_q, dir_sync_q;
  logic                   step_prev_q, dir_prev_q;
  logic [DCW-1:0]         dir_cnt_q, dir_cnt_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0]       steps_q, steps_d;
  logic [TW-1:0]          timer_q, timer_d;
  state_t                 state_q, state_d;
  logic                   done_q, done_d;
  logic                   dir_err_q, dir_err_d;
  logic                   lim_err_q, lim_err_d;

  logic step_s, dir_s, step_edge, dir_chg, dir_viol, lim_hit;

  // Stage 0: input synchronisers
  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_sync_q <= '0;
      dir_sync_q  <= '0;
    end else begin
      step_sync_q[0] <= i_step;
      dir_sync_q[0]  <= i_direction;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        step_sync_q[i] <= step_sync_q[i-1];
        dir_sync_q[i]  <= dir_sync_q[i-1];
      end
    end
  end

  // Stage 1: edge detection, setup check and position update
  assign step_s    = step_sync_q[SYNC_STAGES-1];
  assign dir_s     = dir_sync_q[SYNC_STAGES-1];
  assign step_edge = step_s & ~step_prev_q;
  assign dir_chg   = dir_s ^ dir_prev_q;
  // A direction flip landing on the step's own cycle counts as zero setup.
  assign dir_viol  = step_edge & (dir_chg | (dir_cnt_q < DCW'(DIR_SETUP)));

  always_comb begin
    dir_cnt_d = dir_cnt_q;
    if (dir_chg)
      dir_cnt_d = '0;
    else if (dir_cnt_q < DCW'(DIR_SETUP))
      dir_cnt_d = dir_cnt_q + DCW'(1);
  end

  always_comb begin
    pos_d = pos_q;
    if (i_preset)
      pos_d = i_preset_val;
    else if (step_edge)
      pos_d = dir_s ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
  end

  assign lim_hit   = (i_preset | step_edge) & out_of_range(pos_d);
  assign dir_err_d = dir_viol ? 1'b1 : (i_clr_err ? 1'b0 : dir_err_q);
  assign lim_err_d = lim_hit  ? 1'b1 : (i_clr_err ? 1'b0 : lim_err_q);

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (step_edge) begin
          state_d = S_MOVING;
          steps_d = CNT_W'(1);
          timer_d = '0;
        end
      end
      S_MOVING: begin
        if (step_edge) begin
          steps_d = sat_inc(steps_q);
          timer_d = '0;
        end else if (timer_q == TW'(IDLE_CYCLES - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 2: registered state and outputs
  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_prev_q <= 1'b0;
      dir_prev_q  <= 1'b0;
      dir_cnt_q   <= '0;
      pos_q       <= '0;
      steps_q     <= '0;
      timer_q     <= '0;
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      dir_err_q   <= 1'b0;
      lim_err_q   <= 1'b0;
    end else begin
      step_prev_q <= step_s;
      dir_prev_q  <= dir_s;
      dir_cnt_q   <= dir_cnt_d;
      pos_q       <= pos_d;
      steps_q     <= steps_d;
      timer_q     <= timer_d;
      state_q     <= state_d;
      done_q      <= done_d;
      dir_err_q   <= dir_err_d;
      lim_err_q   <= lim_err_d;
    end
  end

  assign o_position   = pos_q;
  assign o_move_steps = steps_q;
  assign o_moving     = (state_q == S_MOVING);
  assign o_move_done  = done_q;
  assign o_dir_err    = dir_err_q;
  assign o_limit_err  = lim_err_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Scoreboard bench for step_dir_decoder: stimulus pushes expected position and
// move-done events from a plain arithmetic model; a negedge monitor pops and compares.
module tb_step_dir_decoder;
  localparam int POS_W = 16;
  localparam int CNT_W = 15;
  localparam int S     = 2;
  localparam int DS    = 4;
  localparam int IDLE  = 300;
  localparam int PMIN  = -16000;
  localparam int PMAX  = 16000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step = 1'b0;
  logic dir = 1'b1;
  logic preset = 1'b0;
  logic clr = 1'b0;
  logic signed [POS_W-1:0] preset_val = '0;
  logic signed [POS_W-1:0] o_position;
  logic [CNT_W-1:0] o_move_steps;
  logic o_moving, o_move_done, o_dir_err, o_limit_err;

  step_dir_decoder #(
    .POS_W(POS_W), .CNT_W(CNT_W), .SYNC_STAGES(S), .DIR_SETUP(DS),
    .IDLE_CYCLES(IDLE), .POS_MIN(PMIN), .POS_MAX(PMAX)
  ) dut (
    .i_Clk(clk), .i_rst_n(rst_n), .i_step(step), .i_direction(dir),
    .i_preset(preset), .i_preset_val(preset_val), .i_clr_err(clr),
    .o_position(o_position), .o_move_steps(o_move_steps), .o_moving(o_moving),
    .o_move_done(o_move_done), .o_dir_err(o_dir_err), .o_limit_err(o_limit_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int pos; int due; bit lim; bit derr; int steps; bit moving;} pos_ev_t;
  typedef struct {int due; int steps; int pos;} done_ev_t;
  pos_ev_t  pos_q[$];
  done_ev_t done_q[$];

  int checks = 0;
  int fails  = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the axis: position, sticky flags, move state, last direction-change sample.
  int m_pos = 0, m_steps = 0, k_dir = 0, last_upd = 0;
  bit m_lim = 0, m_derr = 0, m_moving = 0;

  function automatic int wrap(int x);
    logic signed [POS_W-1:0] t;
    t = x[POS_W-1:0];
    return int'(t);
  endfunction

  function automatic bit outside(int p);
    return (p < PMIN) || (p > PMAX);
  endfunction

  int prev_pos = 0;
  always @(negedge clk) begin
    pos_ev_t  e;
    done_ev_t d;
    if (!rst_n) begin
      prev_pos <= 0;
    end else begin
      if (int'(o_position) != prev_pos) begin
        if (pos_q.size() == 0) begin
          check("pos_unexpected_change", int'(o_position), prev_pos);
        end else begin
          e = pos_q.pop_front();
          check("pos_value", int'(o_position), e.pos);
          check("pos_cycle", cyc, e.due);
          check("pos_limit_err", int'(o_limit_err), int'(e.lim));
          check("pos_dir_err", int'(o_dir_err), int'(e.derr));
          check("pos_move_steps", int'(o_move_steps), e.steps);
          check("pos_moving", int'(o_moving), int'(e.moving));
        end
        prev_pos <= int'(o_position);
      end
      if (o_move_done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", int'(o_move_done), 0);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d.due);
          check("done_steps", int'(o_move_steps), d.steps);
          check("done_pos", int'(o_position), d.pos);
          check("done_moving_low", int'(o_moving), 0);
        end
      end
    end
  end

  task automatic set_dir(bit v);
    if (v != dir) begin
      dir = v;
      k_dir = cyc + 1;
    end
  endtask

  task automatic step_pulse(int hi, int lo);
    int k = cyc + 1;
    if (k - k_dir <= DS) m_derr = 1;
    m_pos = wrap(m_pos + (dir ? 1 : -1));
    if (outside(m_pos)) m_lim = 1;
    if (!m_moving) begin
      m_moving = 1;
      m_steps = 1;
    end else if (m_steps < (1 << CNT_W) - 1) begin
      m_steps++;
    end
    last_upd = k + S;
    pos_q.push_back('{m_pos, k + S, m_lim, m_derr, m_steps, 1'b1});
    step = 1'b1;
    repeat (hi) @(negedge clk);
    step = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic end_move();
    done_q.push_back('{last_upd + IDLE, m_steps, m_pos});
    m_moving = 0;
    repeat (last_upd + IDLE + 3 - cyc) @(negedge clk);
  endtask

  task automatic do_preset(int v);
    repeat (S + 2) @(negedge clk);
    v = wrap(v);
    preset_val = POS_W'(v);
    preset = 1'b1;
    if (v != m_pos) begin
      m_pos = v;
      if (outside(m_pos)) m_lim = 1;
      pos_q.push_back('{m_pos, cyc + 1, m_lim, m_derr, m_steps, m_moving});
    end
    @(negedge clk);
    preset = 1'b0;
  endtask

  task automatic do_clr();
    repeat (S + 2) @(negedge clk);
    clr = 1'b1;
    m_lim = 0;
    m_derr = 0;
    @(negedge clk);
    clr = 1'b0;
    check("clr_dir_err", int'(o_dir_err), 0);
    check("clr_limit_err", int'(o_limit_err), 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_position"}, int'(o_position), 0);
    check({tag, "_move_steps"}, int'(o_move_steps), 0);
    check({tag, "_moving"}, int'(o_moving), 0);
    check({tag, "_move_done"}, int'(o_move_done), 0);
    check({tag, "_dir_err"}, int'(o_dir_err), 0);
    check({tag, "_limit_err"}, int'(o_limit_err), 0);
  endtask

  initial begin
    int v;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    k_dir = cyc + 1;
    repeat (20) @(negedge clk);

    // Scenario 1: 100 up-steps with direction held from reset
    for (int i = 0; i < 100; i++) step_pulse(4, 6);
    end_move();
    check("s1_position", int'(o_position), 100);
    check("s1_move_steps", int'(o_move_steps), 100);
    check("s1_dir_err", int'(o_dir_err), 0);

    // Scenario 2: 250 down-steps
    set_dir(1'b0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 250; i++) step_pulse(4, 6);
    end_move();
    check("s2_position", int'(o_position), -150);
    check("s2_move_steps", int'(o_move_steps), 250);

    // Scenario 3: direction flipped 2 clocks before a step
    set_dir(1'b1);
    repeat (2) @(negedge clk);
    step_pulse(4, 6);
    for (int i = 0; i < 3; i++) step_pulse(4, 6);
    end_move();
    check("s3_dir_err_sticky", int'(o_dir_err), 1);
    do_clr();

    // Scenario 4: soft upper limit crossed
    do_preset(15999);
    step_pulse(4, 6);
    step_pulse(4, 6);
    end_move();
    check("s4_position", int'(o_position), 16001);
    check("s4_limit_err", int'(o_limit_err), 1);
    do_clr();

    // Scenario 5: wrap, then a step exactly on the idle-timeout cycle
    do_preset(32767);
    step_pulse(4, 6);
    repeat (last_upd + IDLE - S - 1 - cyc) @(negedge clk);
    step_pulse(4, 6);
    step_pulse(4, 6);
    end_move();
    check("s5_position", int'(o_position), -32766);
    check("s5_move_steps", int'(o_move_steps), 3);
    do_clr();

    // Scenario 6: randomized moves, direction changes, presets and clears
    for (int m = 0; m < 6; m++) begin
      int n = $urandom_range(5, 30);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          set_dir(~dir);
          repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        step_pulse($urandom_range(1, 4), $urandom_range(1, 6));
      end
      end_move();
      if ($urandom_range(0, 1) == 1) begin
        do begin
          v = (m % 2 == 0) ? $urandom_range(15980, 16020) : -$urandom_range(15980, 16020);
        end while (wrap(v) == m_pos);
        do_preset(v);
      end
      if ($urandom_range(0, 2) == 0) do_clr();
    end

    // Scenario 7: reset in the middle of a move
    do_clr();
    set_dir(1'b1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 37; i++) step_pulse(4, 6);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    pos_q.delete();
    done_q.delete();
    m_pos = 0; m_steps = 0; m_lim = 0; m_derr = 0; m_moving = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k_dir = cyc + 1;
    repeat (IDLE + 50) @(negedge clk);
    check_all_zero("postreset");

    check("pos_queue_drained", pos_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
